// File: rtl/bsg_manycore_pkg.sv
// Shared manycore testbench types.
//   bsg_spmd_run_state_e : states of the SPMD run controller
//   bsg_spmd_safe_clog2  : clog2 that never returns a zero width
package bsg_manycore_pkg;

  typedef enum logic [2:0] {
    TAG_WAIT,
    RST_HOLD,
    LOAD,
    RUN,
    DONE,
    TIMEOUT
  } bsg_spmd_run_state_e;

  function automatic int bsg_spmd_safe_clog2(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/bsg_spmd_finish_tracker.sv
// Counts finish packets during a run and flags the cycle in which the
// final one arrives.
//   clk_i, reset_i : clock, synchronous active-high reset (clears count)
//   v_i            : one finish packet counted this cycle (already gated to RUN)
//   complete_o     : count plus this cycle's packet reaches num_finish_p
module bsg_spmd_finish_tracker
  import bsg_manycore_pkg::*;
#(
  parameter int num_finish_p = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic v_i,
  output logic complete_o
);

  localparam int cnt_w_lp = bsg_spmd_safe_clog2(num_finish_p + 1);

  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic [cnt_w_lp:0]   sum;

  // One extra bit so the compare never aliases on overflow.
  assign sum        = {1'b0, cnt_q} + {{cnt_w_lp{1'b0}}, v_i};
  assign complete_o = (sum == (cnt_w_lp+1)'(num_finish_p));
  assign cnt_d      = v_i ? sum[cnt_w_lp-1:0] : cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bsg_nonsynth_spmd_run_ctrl.sv
// Sequences one SPMD run: wait for tag programming, hold host-IO reset,
// wait for the loader, then run and count finish packets. Timestamps
// print_stat packets with the run-relative cycle count.
// Optional watchdog: define BSG_SPMD_RUN_WATCHDOG_EN to end the run in
// TIMEOUT after timeout_cycles_p RUN cycles without completion.
// Ports:
//   clk_i, reset_i      : clock, synchronous active-high reset
//   tag_done_i          : tag chain programmed (level)
//   loader_done_i       : loader finished
//   finish_v_i          : finish packet this cycle
//   print_stat_v_i/tag_i: print_stat packet
//   io_reset_o          : host IO reset
//   run_o/done_o/timeout_o : run status (done/timeout sticky)
//   finish_early_o      : pulse, finish seen before RUN
//   stat_v_o/tag_o/cycle_o : registered print_stat with timestamp
//   cycle_ctr_o         : run cycle count
module bsg_nonsynth_spmd_run_ctrl
  import bsg_manycore_pkg::*;
#(
  parameter int reset_depth_p    = 3,
  parameter int num_finish_p     = 1,
  parameter int data_width_p     = 32,
  parameter int ctr_width_p      = 32,
  parameter int timeout_cycles_p = 10000000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    tag_done_i,
  input  logic                    loader_done_i,
  input  logic                    finish_v_i,
  input  logic                    print_stat_v_i,
  input  logic [data_width_p-1:0] print_stat_tag_i,
  output logic                    io_reset_o,
  output logic                    run_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic                    finish_early_o,
  output logic                    stat_v_o,
  output logic [data_width_p-1:0] stat_tag_o,
  output logic [ctr_width_p-1:0]  stat_cycle_o,
  output logic [ctr_width_p-1:0]  cycle_ctr_o
);

  localparam int hold_w_lp = bsg_spmd_safe_clog2(reset_depth_p);
  localparam logic [hold_w_lp-1:0] hold_init_lp = hold_w_lp'(reset_depth_p - 1);

  bsg_spmd_run_state_e     state_q;
  logic [hold_w_lp-1:0]    hold_cnt_q;
  logic [ctr_width_p-1:0]  cycle_ctr_q;
  logic                    io_reset_q, run_q, done_q, finish_early_q;
  logic                    stat_v_q;
  logic [data_width_p-1:0] stat_tag_q;
  logic [ctr_width_p-1:0]  stat_cycle_q;

  logic in_run, pre_run, stat_v_d, finish_complete;

  assign in_run   = (state_q == RUN);
  assign pre_run  = (state_q == TAG_WAIT) || (state_q == RST_HOLD) || (state_q == LOAD);
  assign stat_v_d = print_stat_v_i && ((state_q == LOAD) || in_run);

  bsg_spmd_finish_tracker #(
    .num_finish_p(num_finish_p)
  ) finish_tracker (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (finish_v_i & in_run),
    .complete_o (finish_complete)
  );

`ifdef BSG_SPMD_RUN_WATCHDOG_EN
  localparam logic [ctr_width_p-1:0] wd_last_lp = ctr_width_p'(timeout_cycles_p - 1);
  logic timeout_q;
  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (timeout_cycles_p != 0);
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= TAG_WAIT;
      hold_cnt_q     <= '0;
      cycle_ctr_q    <= '0;
      io_reset_q     <= 1'b1;
      run_q          <= 1'b0;
      done_q         <= 1'b0;
      finish_early_q <= 1'b0;
      stat_v_q       <= 1'b0;
      stat_tag_q     <= '0;
      stat_cycle_q   <= '0;
`ifdef BSG_SPMD_RUN_WATCHDOG_EN
      timeout_q      <= 1'b0;
`endif
    end else begin
      finish_early_q <= finish_v_i & pre_run;
      stat_v_q       <= stat_v_d;
      // Timestamp uses the pre-increment count of the accepting cycle.
      if (stat_v_d) begin
        stat_tag_q   <= print_stat_tag_i;
        stat_cycle_q <= cycle_ctr_q;
      end
      unique case (state_q)
        TAG_WAIT: if (tag_done_i) begin
          state_q    <= RST_HOLD;
          hold_cnt_q <= hold_init_lp;
        end
        RST_HOLD: begin
          if (hold_cnt_q == '0) begin
            state_q    <= LOAD;
            io_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        LOAD: if (loader_done_i) begin
          state_q     <= RUN;
          run_q       <= 1'b1;
          cycle_ctr_q <= '0;
        end
        RUN: begin
          // Completion is checked first so it wins over a same-cycle expiry;
          // the counter only advances while the run continues.
          if (finish_complete) begin
            state_q <= DONE;
            run_q   <= 1'b0;
            done_q  <= 1'b1;
          end
`ifdef BSG_SPMD_RUN_WATCHDOG_EN
          else if (cycle_ctr_q == wd_last_lp) begin
            state_q   <= TIMEOUT;
            run_q     <= 1'b0;
            timeout_q <= 1'b1;
            $error("bsg_nonsynth_spmd_run_ctrl: watchdog expired after %0d cycles", timeout_cycles_p);
          end
`endif
          else if (cycle_ctr_q != '1) begin
            cycle_ctr_q <= cycle_ctr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_reset_o     = io_reset_q;
  assign run_o          = run_q;
  assign done_o         = done_q;
  assign finish_early_o = finish_early_q;
  assign stat_v_o       = stat_v_q;
  assign stat_tag_o     = stat_tag_q;
  assign stat_cycle_o   = stat_cycle_q;
  assign cycle_ctr_o    = cycle_ctr_q;

endmodule
